ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the Pong game FSM. It samples the raw PS/2 clock and data lines and deserialises 11-bit device-to-host frames. It decodes the scan-code set-2 prefixes and delivers one make code per key press on tasta, with a single-cycle done strobe. Break (release) sequences are consumed internally and never reach the game FSM.

Parameters:
FILTER_LEN, 8, number of consecutive identical samples of ps2_clk needed before the filtered clock changes level (glitch filter depth).
TIMEOUT_CYCLES, 12500, idle system-clock cycles allowed between ps2_clk falling edges inside a frame before the frame is aborted (250 us at 50 MHz).

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock from connector, asynchronous
ps2_data  input  1  raw PS/2 data from connector, asynchronous
tasta  output  8  last accepted make code; held stable until the next accepted code
done  output  1  one-cycle strobe, high in the same cycle tasta takes a new value
frame_err  output  1  one-cycle strobe on a parity or stop-bit error

Behaviour:
- Reset (async, active-low): tasta=8'h00, done=0, frame_err=0, state=IDLE, all counters and flags cleared. Filtered clock resets to 1.
- Input conditioning: 2-flop synchroniser on ps2_clk and ps2_data.
  - Filtered clock takes the synchronised value after FILTER_LEN identical consecutive samples.
  - Falling edge = filtered clock goes 1->0. Data is sampled on that cycle.
- Frame format: start(0), d0..d7 LSB first, odd parity, stop(1).
- FSM states:
  - IDLE: on a falling edge with data=0, go to RECEIVE with bit_cnt=0. If data=1, ignore the edge and stay in IDLE (no error).
  - RECEIVE: each falling edge shifts data into a 10-bit shift register and increments bit_cnt. After the 10th post-start edge (bit_cnt=10), go to CHECK.
  - RECEIVE timeout: a timeout counter clears on every falling edge. If it reaches TIMEOUT_CYCLES, go to IDLE, discard the partial frame, and raise no error strobe.
  - CHECK (1 cycle): the frame is valid if stop=1 and XOR(d7..d0, parity)=1. If invalid, pulse frame_err, clear break_pending and ext_pending, and go to IDLE. If valid, run the decode step, then go to IDLE.
- Decode step (valid frame with code c):
  - c=8'hF0: set break_pending; no output.
  - c=8'hE0: set ext_pending; no output. Extended codes are passed through un-prefixed.
  - Otherwise, if break_pending: clear break_pending and ext_pending; no output.
  - Otherwise: tasta<=c, done<=1 for exactly one cycle, clear ext_pending.
- Latency: done asserts 2 cycles after the falling edge that samples the stop bit (the edge cycle, CHECK, then the registered output).
- Simultaneous events: a falling edge in the CHECK cycle is not expected, because PS/2 clock periods are much longer than 2 cycles; if one occurs it is dropped.
- Reset mid-frame: abandons the frame immediately and clears pending prefixes.

Optional Feature:
Macro PS2_TYPEMATIC_FILTER_EN.
- Defined: the block keeps last_make (reset 8'h00).
  - A make code equal to last_make is suppressed (no done) until the matching break sequence F0,c clears last_make to 8'h00.
  - A different make code passes normally and overwrites last_make.
  - The result is one done per physical press, even while the key is held.
- Undefined: every typematic repeat from the keyboard produces its own done strobe.

Decomposition:
- Shared package pong_pkg holds:
  - scan-code constants (F0, E0, A, D, J, L, 1, 2, SPACE, ESC), so the game FSM and this block share one definition;
  - the state enum IDLE/RECEIVE/CHECK.
- Sub-module ps2_input_filter: synchroniser plus glitch filter plus falling-edge detect. Outputs fall_edge and data_s. It is instantiated once.

Test Plan:
- Valid frame 8'h29 (SPACE, parity 0, stop 1) -> tasta=8'h29 and a single done pulse 2 cycles after the stop edge; frame_err=0.
- Sequence 1C, F0, 1C -> exactly one done, with tasta=8'h1C; tasta is still 8'h1C after the break.
- Sequence E0, 75 -> one done with tasta=8'h75; no done for the E0 byte.
- Frame 8'h23 with parity bit flipped -> frame_err pulses once, no done, and tasta is unchanged from its prior value.
- 5 bits sent, then the clock held high for TIMEOUT_CYCLES+10 -> return to IDLE with no strobes; a following valid 8'h4B frame yields done with tasta=8'h4B.
- With PS2_TYPEMATIC_FILTER_EN: 23, 23, 23, F0, 23, 23 -> exactly two done pulses, both with tasta=8'h23. Without the macro the same sequence gives four. A 1-cycle glitch on ps2_clk produces no edge in either build.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: PS/2 set-2 scan codes used by the game and the
// keyboard receiver, plus the receiver frame-state enum.
package pong_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    CHECK
  } ps2_state_t;

  // Captured frame is {stop, parity, d7..d0}; odd parity over data+parity.
  function automatic logic frame_ok(input logic [9:0] f);
    return f[9] & (^f[8:0]);
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// PS/2 line conditioning: 2-flop synchronisers, ps2_clk glitch filter and
// falling-edge detect on the filtered clock. fall_edge is a one-cycle pulse.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_edge,
  output logic data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic          filt_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      cnt      <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_d   <= filt;
      // cnt tracks how many consecutive samples disagree with the filtered level
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign fall_edge = filt_d & ~filt;
  assign data_s    = dat_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises frames and delivers one make code per
// press on tasta/done; break sequences are absorbed. PS2_TYPEMATIC_FILTER_EN
// suppresses typematic repeats of a held key.
module ps2_keyboard_rx
  import pong_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] tasta,
  output logic       done,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall_edge;
  logic data_s;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall_edge(fall_edge),
    .data_s   (data_s)
  );

  ps2_state_t    state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [9:0]    shreg, shreg_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [7:0]    tasta_n;
  logic          done_n;
  logic          err_n;
  logic          brk, brk_n;
  logic          ext, ext_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0]    last_make, last_make_n;
`endif

  logic [7:0] code;
  assign code = shreg[7:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      tasta     <= 8'h00;
      done      <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      to_cnt    <= to_cnt_n;
      tasta     <= tasta_n;
      done      <= done_n;
      frame_err <= err_n;
      brk       <= brk_n;
      ext       <= ext_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make <= last_make_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    to_cnt_n  = to_cnt;
    tasta_n   = tasta;
    done_n    = 1'b0;
    err_n     = 1'b0;
    brk_n     = brk;
    ext_n     = ext;
`ifdef PS2_TYPEMATIC_FILTER_EN
    last_make_n = last_make;
`endif
    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        to_cnt_n  = '0;
        if (fall_edge && !data_s) state_n = RECEIVE;
      end
      RECEIVE: begin
        if (fall_edge) begin
          shreg_n   = {data_s, shreg[9:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          to_cnt_n  = '0;
          if (bit_cnt == 4'd9) state_n = CHECK;
        end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
          state_n = IDLE;
        end else begin
          to_cnt_n = to_cnt + TW'(1);
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (!frame_ok(shreg)) begin
          err_n = 1'b1;
          brk_n = 1'b0;
          ext_n = 1'b0;
        end else if (code == SC_BREAK) begin
          brk_n = 1'b1;
        end else if (code == SC_EXT) begin
          ext_n = 1'b1;
        end else if (brk) begin
          brk_n = 1'b0;
          ext_n = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (code == last_make) last_make_n = 8'h00;
`endif
        end else begin
          ext_n = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (code != last_make) begin
            tasta_n     = code;
            done_n      = 1'b1;
            last_make_n = code;
          end
`else
          tasta_n = code;
          done_n  = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised and directed frames against a scan-code level reference model.
module tb_ps2_keyboard_rx;

  localparam int FL   = 8;
  localparam int TO   = 12500;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] tasta;
  logic       done;
  logic       frame_err;

  always #5 clock = ~clock;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .tasta    (tasta),
    .done     (done),
    .frame_err(frame_err)
  );

  int cyc = 0;
  always @(posedge clock) cyc++;

  int done_cnt = 0, err_cnt = 0, last_done_cyc = 0, stop_cyc = 0;
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: scan-code rules applied per received frame
  int m_tasta = 0, m_done = 0, m_err = 0, m_last = 0;
  bit m_brk = 0, m_ext = 0;

  task automatic model_frame(input int c, input bit ok);
    if (!ok) begin
      m_err++;
      m_brk = 0;
      m_ext = 0;
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else if (m_brk) begin
      m_brk = 0;
      m_ext = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (c == m_last) m_last = 0;
`endif
    end else begin
      m_ext = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (c != m_last) begin
        m_tasta = c;
        m_done++;
        m_last = c;
      end
`else
      m_tasta = c;
      m_done++;
`endif
    end
  endtask

  task automatic send_raw(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_data = f[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [7:0] c, input bit bp, input bit bs);
    logic [10:0] f;
    f = {~bs, (~^c) ^ bp, c, 1'b0};
    send_raw(f, 11);
    repeat (FL + 10) @(negedge clock);
    model_frame(int'(c), !bp && !bs);
    chk({tag, ".done"}, done_cnt, m_done);
    chk({tag, ".err"}, err_cnt, m_err);
    chk({tag, ".tasta"}, int'(tasta), m_tasta);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    int d0, r;
    bit bp, bs;

    repeat (5) @(negedge clock);
    chk("rst.tasta", int'(tasta), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(frame_err), 0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    frame("space", 8'h29, 0, 0);
    chk("latency", last_done_cyc - stop_cyc, FL + 4);

    d0 = done_cnt;
    frame("a_make", 8'h1C, 0, 0);
    frame("a_f0", 8'hF0, 0, 0);
    frame("a_brk", 8'h1C, 0, 0);
    chk("a_seq.count", done_cnt - d0, 1);

    d0 = done_cnt;
    frame("ext_e0", 8'hE0, 0, 0);
    frame("ext_75", 8'h75, 0, 0);
    chk("ext.count", done_cnt - d0, 1);

    frame("parity", 8'h23, 1, 0);
    frame("stop", 8'h3B, 0, 1);

    send_raw({2'b11, 8'hA5, 1'b0}, 5);
    repeat (TO + 10) @(negedge clock);
    chk("timeout.done", done_cnt, m_done);
    chk("timeout.err", err_cnt, m_err);
    frame("after_to", 8'h4B, 0, 0);

    @(negedge clock);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    @(negedge clock);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (50) @(negedge clock);
    frame("glitch", 8'h16, 0, 0);

    d0 = done_cnt;
    frame("tm1", 8'h23, 0, 0);
    frame("tm2", 8'h23, 0, 0);
    frame("tm3", 8'h23, 0, 0);
    frame("tm_f0", 8'hF0, 0, 0);
    frame("tm4", 8'h23, 0, 0);
    frame("tm5", 8'h23, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic.count", done_cnt - d0, 2);
`else
    chk("typematic.count", done_cnt - d0, 4);
`endif

    frame("rst_f0", 8'hF0, 0, 0);
    send_raw({2'b11, 8'h5A, 1'b0}, 4);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    m_tasta = 0;
    m_brk = 0;
    m_ext = 0;
    m_last = 0;
    repeat (10) @(negedge clock);
    chk("midrst.tasta", int'(tasta), 0);
    frame("midrst_1c", 8'h1C, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) c = 8'hF0;
      else if (r == 1) c = 8'hE0;
      else if (r < 5) c = 8'(16 + $urandom_range(0, 3) * 7);
      else c = 8'($urandom_range(1, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      frame("rand", c, bp, bs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
